// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding, default timing constants and saturating helpers
package alarm_pkg;

    typedef enum logic [2:0] {IDLE, PREVIEW, BEEP_ON, BEEP_OFF, PAUSE} alarm_state_t;

    localparam int DEF_DUTY_W         = 8;
    localparam int DEF_DUTY_STEP      = 16;
    localparam int DEF_ON_CYCLES      = 1000;
    localparam int DEF_OFF_CYCLES     = 1000;
    localparam int DEF_BEEPS          = 3;
    localparam int DEF_PAUSE_CYCLES   = 4000;
    localparam int DEF_MAX_ROUNDS     = 8;
    localparam int DEF_PREVIEW_CYCLES = 2000;
    localparam int DEF_RAMP_DIV       = 4;

    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                            input int unsigned lim);
        return (a + b > lim) ? lim : a + b;
    endfunction

    function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
        return (a > b) ? a - b : 0;
    endfunction

endpackage

// File: rtl/alarm_timer.sv
// alarm_timer: loadable down-counter, done while the count sits at zero
module alarm_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = load ? load_val : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign done = cnt_q == '0;

endmodule

// File: rtl/pwm_alarm_ctrl.sv
// pwm_alarm_ctrl: user level preview and alarm beep cadence for pwm; ALARM_RAMP_EN adds a per-beep duty ramp
module pwm_alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int DUTY_W         = DEF_DUTY_W,
    parameter int DUTY_STEP      = DEF_DUTY_STEP,
    parameter int ON_CYCLES      = DEF_ON_CYCLES,
    parameter int OFF_CYCLES     = DEF_OFF_CYCLES,
    parameter int BEEPS          = DEF_BEEPS,
    parameter int PAUSE_CYCLES   = DEF_PAUSE_CYCLES,
    parameter int MAX_ROUNDS     = DEF_MAX_ROUNDS,
    parameter int PREVIEW_CYCLES = DEF_PREVIEW_CYCLES,
    parameter int RAMP_DIV       = DEF_RAMP_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              incr_req,
    input  logic              decr_req,
    input  logic              alarm_trig,
    input  logic              alarm_ack,
    output logic [DUTY_W-1:0] duty,
    output logic              pwm_en,
    output logic [DUTY_W-1:0] level,
    output logic              alarm_active
);

    localparam int MAX_A   = ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES;
    localparam int MAX_B   = PAUSE_CYCLES > PREVIEW_CYCLES ? PAUSE_CYCLES : PREVIEW_CYCLES;
    localparam int MAX_CYC = MAX_A > MAX_B ? MAX_A : MAX_B;
    localparam int TW      = $clog2(MAX_CYC) + 1;
    localparam int BW      = $clog2(BEEPS + 1);
    localparam int RW      = $clog2(MAX_ROUNDS + 2);

    localparam logic [TW-1:0] T_ON    = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] T_OFF   = TW'(OFF_CYCLES - 1);
    localparam logic [TW-1:0] T_PAUSE = TW'(PAUSE_CYCLES - 1);
    localparam logic [TW-1:0] T_PRV   = TW'(PREVIEW_CYCLES - 1);
    localparam logic [BW-1:0] BEEPS_L  = BW'(BEEPS);
    localparam logic [RW-1:0] ROUNDS_L = RW'(MAX_ROUNDS);

    if (BEEPS < 1 || RAMP_DIV < 1) begin : g_bad_param
        $error("pwm_alarm_ctrl: BEEPS and RAMP_DIV must be at least 1");
    end

    alarm_state_t      state_q, state_d;
    logic [BW-1:0]     beep_q, beep_d;
    logic [RW-1:0]     round_q, round_d;
    logic [DUTY_W-1:0] level_q, level_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              pwm_en_q, pwm_en_d;
    logic              active_q, active_d;
    logic              load, done, adj, active;
    logic [TW-1:0]     load_val;

    alarm_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    always_comb begin
        adj     = incr_req | decr_req;
        active  = state_q == BEEP_ON || state_q == BEEP_OFF || state_q == PAUSE;
        state_d = state_q;
        beep_d  = beep_q;
        round_d = round_q;
        load    = 1'b0;
        load_val = '0;
        case (state_q)
            IDLE, PREVIEW: begin
                if (alarm_trig) begin
                    state_d  = BEEP_ON;
                    load     = 1'b1;
                    load_val = T_ON;
                    beep_d   = '0;
                    round_d  = '0;
                end else if (adj) begin
                    state_d  = PREVIEW;
                    load     = 1'b1;
                    load_val = T_PRV;
                end else if (state_q == PREVIEW && done) begin
                    state_d = IDLE;
                end
            end
            BEEP_ON: begin
                if (done) begin
                    state_d  = BEEP_OFF;
                    load     = 1'b1;
                    load_val = T_OFF;
                end
            end
            BEEP_OFF: begin
                if (done) begin
                    beep_d   = beep_q + 1'b1;
                    load     = 1'b1;
                    state_d  = (beep_d == BEEPS_L) ? PAUSE : BEEP_ON;
                    load_val = (beep_d == BEEPS_L) ? T_PAUSE : T_ON;
                end
            end
            PAUSE: begin
                if (done) begin
                    beep_d  = '0;
                    round_d = round_q + 1'b1;
                    if (MAX_ROUNDS != 0 && round_d == ROUNDS_L) begin
                        state_d = IDLE;
                        round_d = '0;
                    end else begin
                        state_d  = BEEP_ON;
                        load     = 1'b1;
                        load_val = T_ON;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // acknowledge wins over every other event once the alarm runs
        if (alarm_ack && active) begin
            state_d = IDLE;
            beep_d  = '0;
            round_d = '0;
            load    = 1'b0;
        end
    end

    always_comb begin
        level_d  = (incr_req && !decr_req) ? DUTY_W'(sat_add(32'(level_q), DUTY_STEP, 2**DUTY_W - 1)) :
                   (decr_req && !incr_req) ? DUTY_W'(sat_sub(32'(level_q), DUTY_STEP)) : level_q;
        pwm_en_d = state_q == PREVIEW || state_q == BEEP_ON;
        active_d = active;
    end

`ifdef ALARM_RAMP_EN
    localparam int DW = $clog2(RAMP_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(RAMP_DIV - 1);

    logic [DUTY_W-1:0] ramp_q, ramp_d;
    logic [DW-1:0]     div_q, div_d;

    always_comb begin
        ramp_d = ramp_q;
        div_d  = div_q;
        if (state_d == BEEP_ON && state_q != BEEP_ON) begin
            ramp_d = '0;
            div_d  = '0;
        end else if (state_q == BEEP_ON) begin
            div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            ramp_d = (div_q == DIV_LAST) ? DUTY_W'(sat_add(32'(ramp_q), DUTY_STEP, 32'(level_q))) : ramp_q;
        end
        duty_d = (state_q == PREVIEW) ? level_q :
                 (state_q == BEEP_ON) ? ((ramp_q < level_q) ? ramp_q : level_q) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ramp_q <= '0;
            div_q  <= '0;
        end else begin
            ramp_q <= ramp_d;
            div_q  <= div_d;
        end
    end
`else
    always_comb begin
        duty_d = pwm_en_d ? level_q : '0;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            beep_q   <= '0;
            round_q  <= '0;
            level_q  <= DUTY_W'(2**(DUTY_W - 1));
            duty_q   <= '0;
            pwm_en_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            beep_q   <= beep_d;
            round_q  <= round_d;
            level_q  <= level_d;
            duty_q   <= duty_d;
            pwm_en_q <= pwm_en_d;
            active_q <= active_d;
        end
    end

    assign duty         = duty_q;
    assign pwm_en       = pwm_en_q;
    assign level        = level_q;
    assign alarm_active = active_q;

endmodule

// File: tb/tb_pwm_alarm_ctrl.sv
// tb_pwm_alarm_ctrl: scoreboard bench with a time-based reference model of the alarm cadence
module tb_pwm_alarm_ctrl;

    localparam int ON = 4, OFF = 4, BEEPS = 2, PAUSE = 8, MAXR = 2, PRV = 16, STEP = 16, RDIV = 1;
    localparam int BP = ON + OFF;
    localparam int PERIOD = BEEPS * BP + PAUSE;

    typedef struct {
        int duty;
        bit pwm;
        bit act;
        int level;
    } exp_t;

    logic       clk, rst, incr_req, decr_req, alarm_trig, alarm_ack;
    logic [7:0] duty, level;
    logic       pwm_en, alarm_active;

    exp_t q[$];
    int n_chk = 0, n_fail = 0;
    int on_cnt = 0, act_cnt = 0;
    int m_mode = 0, m_t = 0, m_lvl = 128, m_ramp = 0;

    pwm_alarm_ctrl #(
        .DUTY_W(8), .DUTY_STEP(STEP), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .BEEPS(BEEPS),
        .PAUSE_CYCLES(PAUSE), .MAX_ROUNDS(MAXR), .PREVIEW_CYCLES(PRV), .RAMP_DIV(RDIV)
    ) dut (
        .clk(clk), .rst(rst), .incr_req(incr_req), .decr_req(decr_req),
        .alarm_trig(alarm_trig), .alarm_ack(alarm_ack), .duty(duty), .pwm_en(pwm_en),
        .level(level), .alarm_active(alarm_active)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    function automatic bit beep_on_at(input int t);
        int o = t % PERIOD;
        return o < BEEPS * BP && (o % BP) < ON;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("duty", 32'(duty), e.duty);
                chk("pwm_en", 32'(pwm_en), 32'(e.pwm));
                chk("level", 32'(level), e.level);
                chk("alarm_active", 32'(alarm_active), 32'(e.act));
                if (pwm_en) on_cnt++;
                if (alarm_active) act_cnt++;
            end
        end
    end

    task automatic step(input bit i, input bit d, input bit t, input bit a);
        exp_t e;
        int pre_lvl, pre_t;
        bit pre_on;
        incr_req = i; decr_req = d; alarm_trig = t; alarm_ack = a;
        @(posedge clk);
        pre_lvl = m_lvl;
        pre_t   = m_t;
        pre_on  = (m_mode == 2) && beep_on_at(m_t);
        e.pwm   = (m_mode == 1) || pre_on;
        e.act   = m_mode == 2;
`ifdef ALARM_RAMP_EN
        e.duty  = (m_mode == 1) ? pre_lvl : pre_on ? (m_ramp < pre_lvl ? m_ramp : pre_lvl) : 0;
`else
        e.duty  = e.pwm ? pre_lvl : 0;
`endif
        if (i && !d) m_lvl = (m_lvl + STEP > 255) ? 255 : m_lvl + STEP;
        else if (d && !i) m_lvl = (m_lvl < STEP) ? 0 : m_lvl - STEP;
        if (m_mode == 2) begin
            if (a) m_mode = 0;
            else begin
                m_t++;
                if (MAXR != 0 && m_t == MAXR * PERIOD) m_mode = 0;
            end
        end else if (t) begin
            m_mode = 2; m_t = 0;
        end else if (i || d) begin
            m_mode = 1; m_t = 0;
        end else if (m_mode == 1) begin
            m_t++;
            if (m_t == PRV) m_mode = 0;
        end
        if (pre_on && ((pre_t % BP) % RDIV) == RDIV - 1)
            m_ramp = (m_ramp + STEP > pre_lvl) ? pre_lvl : m_ramp + STEP;
        if (m_mode == 2 && beep_on_at(m_t) && (m_t % PERIOD) % BP == 0) m_ramp = 0;
        e.level = m_lvl;
        q.push_back(e);
        #1;
        incr_req = 0; decr_req = 0; alarm_trig = 0; alarm_ack = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0);
    endtask

    task automatic flush();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 0;
        #1;
        chk("rst_duty", 32'(duty), 0);
        chk("rst_pwm_en", 32'(pwm_en), 0);
        chk("rst_level", 32'(level), 128);
        chk("rst_active", 32'(alarm_active), 0);
        m_mode = 0; m_t = 0; m_lvl = 128; m_ramp = 0;
        @(negedge clk);
        #2 rst = 1;
    endtask

    int ramp_exp[4];

    initial begin
        rst = 0; incr_req = 0; decr_req = 0; alarm_trig = 0; alarm_ack = 0;
        do_reset();
        step(0, 0, 0, 0);
        flush();
        chk("rel_level", 32'(level), 128);
        chk("rel_pwm_en", 32'(pwm_en), 0);

        repeat (9) step(1, 0, 0, 0);
        flush();
        chk("sat_hi", 32'(level), 255);
        idle(20);
        do_reset();
        repeat (9) step(0, 1, 0, 0);
        flush();
        chk("sat_lo", 32'(level), 0);
        repeat (8) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        flush();
        chk("both_same", 32'(level), 128);
        idle(20);

        on_cnt = 0;
        step(1, 0, 0, 0);
        idle(30);
        chk("preview_len", 32'(on_cnt), 16);
        on_cnt = 0;
        step(1, 0, 0, 0);
        idle(9);
        step(1, 0, 0, 0);
        idle(30);
        chk("preview_ext", 32'(on_cnt), 26);

        on_cnt = 0; act_cnt = 0;
        step(0, 0, 1, 0);
        idle(60);
        chk("alarm_on", 32'(on_cnt), 16);
        chk("alarm_active_len", 32'(act_cnt), 48);

        act_cnt = 0;
        step(0, 0, 1, 0);
        idle(9);
        step(0, 0, 0, 1);
        idle(10);
        chk("ack_beep2", 32'(act_cnt), 10);

        act_cnt = 0;
        step(0, 0, 1, 0);
        idle(5);
        step(0, 0, 1, 1);
        idle(10);
        chk("trig_ack", 32'(act_cnt), 6);
        on_cnt = 0; act_cnt = 0;
        step(0, 0, 1, 0);
        idle(60);
        chk("retrig_on", 32'(on_cnt), 16);
        chk("retrig_active", 32'(act_cnt), 48);

        do_reset();
        repeat (4) step(0, 1, 0, 0);
        idle(20);
`ifdef ALARM_RAMP_EN
        ramp_exp = '{0, 16, 32, 48};
`else
        ramp_exp = '{64, 64, 64, 64};
`endif
        step(0, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0);
            flush();
            chk("beep_duty", 32'(duty), 32'(ramp_exp[k]));
        end
        step(0, 0, 0, 1);
        idle(5);

        step(0, 0, 1, 0);
        idle(10);
        do_reset();

        for (int k = 0; k < 3000; k++)
            step($urandom_range(19) == 0, $urandom_range(19) == 0,
                 $urandom_range(39) == 0, $urandom_range(29) == 0);
        flush();
        chk("queue_drained", 32'(q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
